// File: rtl/apx_error_monitor_if.sv
// apx_error_monitor_if: result-pair collection and error-record handshake bundle
interface apx_error_monitor_if #(parameter int ERR_W = 16);
  logic [31:0] acc_z;
  logic acc_z_stb;
  logic acc_z_ack;
  logic [31:0] apx_z;
  logic apx_z_stb;
  logic apx_z_ack;
  logic [ERR_W-1:0] err_ulp;
  logic [5:0] err_bits;
  logic err_mismatch;
  logic err_stb;
  logic err_ack;
  modport master (
    output acc_z, acc_z_stb, apx_z, apx_z_stb, err_ack,
    input acc_z_ack, apx_z_ack, err_ulp, err_bits, err_mismatch, err_stb
  );
  modport slave (
    input acc_z, acc_z_stb, apx_z, apx_z_stb, err_ack,
    output acc_z_ack, apx_z_ack, err_ulp, err_bits, err_mismatch, err_stb
  );
endinterface

// File: rtl/apx_error_monitor.sv
// apx_error_monitor: pairs accurate/approximate results, reports ULP/bit error and keeps saturating stats
module apx_error_monitor #(
  parameter int ERR_W = 16,
  parameter int CNT_W = 32,
  parameter int TOL = 0
) (
  input  logic clk,
  input  logic rst,
  apx_error_monitor_if.slave bus,
  input  logic clear_stats,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] viol_count,
  output logic [ERR_W-1:0] max_ulp
);
  typedef enum logic [1:0] {COLLECT, COMPARE, OUTPUT} state_t;
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);
  state_t state, state_n;
  logic [31:0] acc_q, apx_q, raw;
  logic acc_full, apx_full, take_acc, take_apx, release_pair, mism, viol;
  logic [30:0] mag_a, mag_b;
  logic [ERR_W-1:0] ulp;
  logic [5:0] bits;
  // Slot acceptance, next state and error arithmetic on the held pair
  always_comb begin
    take_acc = state == COLLECT && !acc_full && bus.acc_z_stb && !bus.acc_z_ack;
    take_apx = state == COLLECT && !apx_full && bus.apx_z_stb && !bus.apx_z_ack;
    release_pair = state == OUTPUT && bus.err_ack;
    state_n = (state == COLLECT && acc_full && apx_full) ? COMPARE :
              (state == COMPARE) ? OUTPUT :
              release_pair ? COLLECT : state;
    mag_a = acc_q[30:0];
    mag_b = apx_q[30:0];
    mism = acc_q != apx_q;
    raw = !mism ? 32'd0 :
          (acc_q[30:23] == 8'hFF || apx_q[30:23] == 8'hFF) ? 32'hFFFF_FFFF :
          (acc_q[31] != apx_q[31]) ? (((mag_a | mag_b) == 31'd0) ? 32'd0 : {1'b0, mag_a} + {1'b0, mag_b}) :
          (mag_a >= mag_b) ? {1'b0, mag_a - mag_b} : {1'b0, mag_b - mag_a};
    ulp = (raw > ERR_MAX) ? '1 : raw[ERR_W-1:0];
    viol = ulp > ERR_W'(TOL);
    bits = 6'($countones(acc_q ^ apx_q));
  end
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= COLLECT;
    else state <= state_n;
  // Input slots with one-cycle registered acks; slots drain once the record is consumed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      apx_q <= '0;
      acc_full <= 1'b0;
      apx_full <= 1'b0;
      bus.acc_z_ack <= 1'b0;
      bus.apx_z_ack <= 1'b0;
    end else begin
      bus.acc_z_ack <= take_acc;
      bus.apx_z_ack <= take_apx;
      if (take_acc) acc_q <= bus.acc_z;
      if (take_apx) apx_q <= bus.apx_z;
      acc_full <= release_pair ? 1'b0 : acc_full | take_acc;
      apx_full <= release_pair ? 1'b0 : apx_full | take_apx;
    end
  // Error record: captured in COMPARE, held until err_ack
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.err_ulp <= '0;
      bus.err_bits <= '0;
      bus.err_mismatch <= 1'b0;
      bus.err_stb <= 1'b0;
    end else if (state == COMPARE) begin
      bus.err_ulp <= ulp;
      bus.err_bits <= bits;
      bus.err_mismatch <= mism;
      bus.err_stb <= 1'b1;
    end else if (release_pair) bus.err_stb <= 1'b0;
  // Saturating statistics; a clear overrides a coincident update
  always_ff @(posedge clk or negedge rst)
    if (!rst || clear_stats) begin
      pair_count <= '0;
      mismatch_count <= '0;
      viol_count <= '0;
      max_ulp <= '0;
    end else if (state == COMPARE) begin
      pair_count <= pair_count + CNT_W'(pair_count != '1);
      mismatch_count <= mismatch_count + CNT_W'(mism && mismatch_count != '1);
      viol_count <= viol_count + CNT_W'(viol && viol_count != '1);
      max_ulp <= (ulp > max_ulp) ? ulp : max_ulp;
    end
endmodule

// File: tb/tb_apx_error_monitor.sv
// tb_apx_error_monitor: directed checks of pairing, error arithmetic, statistics and reset
module tb_apx_error_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_stats = 1'b0;
  logic [31:0] pair_count, mismatch_count, viol_count;
  logic [15:0] max_ulp;
  int vectors = 0;
  int miscompares = 0;
  int lat, acks;
  apx_error_monitor_if #(.ERR_W(16)) bus();
  apx_error_monitor #(.ERR_W(16), .CNT_W(32), .TOL(0)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus.slave),
    .clear_stats(clear_stats),
    .pair_count(pair_count),
    .mismatch_count(mismatch_count),
    .viol_count(viol_count),
    .max_ulp(max_ulp)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int skew,
                          input bit refill, input bit clr, output int lat_o, output int acc_acks);
    bit a_done, b_done;
    int done_cyc;
    a_done = 0;
    b_done = 0;
    done_cyc = -1;
    lat_o = -1;
    acc_acks = 0;
    bus.acc_z = a;
    bus.acc_z_stb = 1'b1;
    bus.apx_z = b;
    bus.apx_z_stb = (skew == 0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus.acc_z_ack) begin
        acc_acks++;
        a_done = 1;
        if (refill) bus.acc_z = 32'h1234_5678;
        else bus.acc_z_stb = 1'b0;
      end
      if (bus.apx_z_ack) begin
        b_done = 1;
        bus.apx_z_stb = 1'b0;
      end
      if (c + 1 == skew) bus.apx_z_stb = 1'b1;
      if (done_cyc < 0 && a_done && b_done) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) clear_stats = clr;
      if (done_cyc >= 0 && c == done_cyc + 2) clear_stats = 1'b0;
      if (bus.err_stb) begin
        lat_o = (done_cyc >= 0) ? c - done_cyc : -1;
        break;
      end
    end
    chk("latency", 64'(lat_o), 64'd2);
  endtask

  task automatic ack_err();
    bus.err_ack = 1'b1;
    @(posedge clk); #1;
    bus.err_ack = 1'b0;
    chk("err_stb_after_ack", 64'(bus.err_stb), 64'd0);
  endtask

  task automatic chk_err(input string tag, input logic [15:0] u, input logic [5:0] b, input logic m);
    chk({tag, "_ulp"}, 64'(bus.err_ulp), 64'(u));
    chk({tag, "_bits"}, 64'(bus.err_bits), 64'(b));
    chk({tag, "_mism"}, 64'(bus.err_mismatch), 64'(m));
  endtask

  task automatic chk_stats(input string tag, input int p, input int m, input int v, input int mx);
    chk({tag, "_pairs"}, 64'(pair_count), 64'(p));
    chk({tag, "_mismatches"}, 64'(mismatch_count), 64'(m));
    chk({tag, "_viols"}, 64'(viol_count), 64'(v));
    chk({tag, "_max"}, 64'(max_ulp), 64'(mx));
  endtask

  initial begin
    bus.acc_z = '0;
    bus.acc_z_stb = 1'b0;
    bus.apx_z = '0;
    bus.apx_z_stb = 1'b0;
    bus.err_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_err_stb", 64'(bus.err_stb), 64'd0);
    chk("rst_acc_ack", 64'(bus.acc_z_ack), 64'd0);
    chk("rst_apx_ack", 64'(bus.apx_z_ack), 64'd0);
    chk_err("rst", 16'd0, 6'd0, 1'b0);
    chk_stats("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pair(32'h40A1_47AE, 32'h40A1_47AE, 0, 0, 0, lat, acks);
    chk_err("equal", 16'd0, 6'd0, 1'b0);
    chk_stats("equal", 1, 0, 0, 0);
    ack_err();

    run_pair(32'h40A1_47AE, 32'h40A1_4700, 0, 0, 0, lat, acks);
    chk_err("ulp174", 16'd174, 6'd5, 1'b1);
    chk_stats("ulp174", 2, 1, 1, 174);
    ack_err();

    run_pair(32'h8000_0000, 32'h0000_0000, 0, 0, 0, lat, acks);
    chk_err("zeros", 16'd0, 6'd1, 1'b1);
    chk_stats("zeros", 3, 2, 1, 174);
    ack_err();

    run_pair(32'h3F80_0000, 32'hBF80_0000, 0, 0, 0, lat, acks);
    chk_err("sign", 16'hFFFF, 6'd1, 1'b1);
    chk_stats("sign", 4, 3, 2, 16'hFFFF);
    ack_err();

    run_pair(32'h7FC0_0000, 32'h7FC0_0000, 0, 0, 0, lat, acks);
    chk_err("nan_eq", 16'd0, 6'd0, 1'b0);
    ack_err();

    run_pair(32'h7FC0_0000, 32'h7F80_0000, 0, 0, 0, lat, acks);
    chk_err("nan_inf", 16'hFFFF, 6'd1, 1'b1);
    chk_stats("nan_inf", 6, 4, 3, 16'hFFFF);
    ack_err();

    run_pair(32'h3F80_0000, 32'h3F80_0002, 0, 0, 1, lat, acks);
    chk_err("clr_cmp", 16'd2, 6'd1, 1'b1);
    chk_stats("clr_cmp", 0, 0, 0, 0);
    ack_err();

    run_pair(32'h4000_0000, 32'h4000_0003, 20, 1, 0, lat, acks);
    chk("skew_acc_acks", 64'(acks), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_acc_ack", 64'(bus.acc_z_ack), 64'd0);
      chk("hold_err_stb", 64'(bus.err_stb), 64'd1);
      chk("hold_ulp", 64'(bus.err_ulp), 64'd3);
    end
    chk_err("skew", 16'd3, 6'd2, 1'b1);
    chk_stats("skew", 1, 1, 1, 3);
    bus.acc_z_stb = 1'b0;
    ack_err();

    run_pair(32'h3F80_0000, 32'h3F80_0004, 0, 0, 0, lat, acks);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_err_stb", 64'(bus.err_stb), 64'd0);
    chk_err("rst2", 16'd0, 6'd0, 1'b0);
    chk_stats("rst2", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pair(32'h3F80_0000, 32'h3F80_0001, 0, 0, 0, lat, acks);
    chk_err("post_rst", 16'd1, 6'd1, 1'b1);
    chk_stats("post_rst", 1, 1, 1, 1);
    ack_err();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apx_error_monitor.md
Name: apx_error_monitor

Overview:
- Downstream stage of the accurate/approximate float multiplier pair.
- Consumes both output_z streams through their stb/ack handshakes and pairs results in arrival order, one per channel.
- Computes a per-pair error (ULP distance and differing-bit count) and emits it through a stb/ack handshake.
- Keeps saturating statistics (pairs, mismatches, tolerance violations, max ULP error) for NAB/BT_RND characterisation runs.

Parameters:
- ERR_W, 16: width of the ULP error field; larger distances saturate to 2^ERR_W-1.
- CNT_W, 32: width of each statistics counter; counters saturate at all-ones.
- TOL, 0: ULP tolerance; a pair whose err_ulp exceeds TOL increments viol_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- acc_z  in  32  accurate multiplier result (IEEE-754 single).
- acc_z_stb  in  1  acc_z valid.
- acc_z_ack  out  1  acc_z accepted.
- apx_z  in  32  approximate multiplier result.
- apx_z_stb  in  1  apx_z valid.
- apx_z_ack  out  1  apx_z accepted.
- err_ulp  out  ERR_W  ULP distance of the current pair.
- err_bits  out  6  popcount(acc ^ apx), range 0..32.
- err_mismatch  out  1  acc != apx (bitwise).
- err_stb  out  1  error record valid.
- err_ack  in  1  error record consumed.
- clear_stats  in  1  synchronous clear of all statistics.
- pair_count  out  CNT_W  pairs compared.
- mismatch_count  out  CNT_W  pairs with err_mismatch = 1.
- viol_count  out  CNT_W  pairs with err_ulp > TOL.
- max_ulp  out  ERR_W  largest err_ulp since the last clear.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs go to 0; both slots become empty; state = COLLECT.
  - A pending record or half-collected pair is discarded.
- States: COLLECT, COMPARE, OUTPUT.
- COLLECT, per channel, independently:
  - If slot empty, stb = 1 and ack = 0: raise ack for exactly one cycle and latch the data into the slot on that edge.
  - ack is registered, so it appears one cycle after stb is sampled.
  - A full slot holds ack low; the producer keeps stb and data stable.
  - Arrival skew between channels is unbounded.
- COLLECT -> COMPARE on the first edge where both slots are full. Both channels accepted on the same edge is legal.
- COMPARE (1 cycle): register err_* and update the statistics, then go to OUTPUT with err_stb = 1.
  - Latency: err_stb rises 2 cycles after the edge that fills the second slot.
- OUTPUT:
  - err_* are held stable while err_stb = 1.
  - On the edge where err_ack = 1: err_stb -> 0, both slots emptied, state -> COLLECT.
  - No acks are issued in COMPARE or OUTPUT.
- ULP rule, with a = acc_z, b = apx_z, mag = bits[30:0]:
  - a == b bitwise: 0.
  - Either exponent == 8'hFF and a != b: saturate.
  - Signs differ: 0 if both mags are 0 (±0); otherwise mag_a + mag_b, saturating.
  - Signs equal: |mag_a - mag_b|, saturating to ERR_W bits.
- Statistics, updated in COMPARE:
  - pair_count += 1.
  - mismatch_count += err_mismatch.
  - viol_count += (err_ulp > TOL).
  - max_ulp = max(max_ulp, err_ulp).
  - All counters saturate and never wrap.
- clear_stats:
  - Zeroes all four statistics on the next edge.
  - If it coincides with COMPARE, the clear wins and the pair is not counted.
  - It does not affect slots, state, or the err_* outputs.

Test Plan:
- acc = apx = 0x40A147AE (5.04), simultaneous stb -> err_stb 2 cycles after the slots fill; err_ulp = 0, err_bits = 0, err_mismatch = 0; pair_count = 1, mismatch_count = 0.
- acc = 0x40A147AE, apx = 0x40A14700, TOL = 0 -> err_ulp = 174, err_bits = 5, err_mismatch = 1; viol_count = 1, max_ulp = 174.
- acc = 0x80000000, apx = 0x00000000 -> err_ulp = 0, err_mismatch = 1. acc = 0x3F800000, apx = 0xBF800000 -> err_ulp = 0xFFFF.
- acc = apx = 0x7FC00000 -> err_ulp = 0. acc = 0x7FC00000, apx = 0x7F800000 -> err_ulp = 0xFFFF.
- apx_z_stb 20 cycles after acc_z_stb; err_ack held low for 10 cycles -> acc_z_ack pulses once and is not re-asserted; no second acc value is accepted; err_* stay stable until err_ack.
- Drive rst low during OUTPUT, then feed a new pair (0x3F800000, 0x3F800001) -> all outputs 0 after reset; the new pair yields err_ulp = 1, pair_count = 1.
